// File: rtl/fetch_controller_if.sv
// Instruction-memory handshake between the fetch controller (master) and imem (slave).
// One request outstanding; the address is held while req is high and ready is low.
interface fetch_controller_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_controller.sv
// IF-stage sequencer: PC, one-outstanding imem fetch, redirect squash, halt; 1-cycle fetch latency,
// stall freezes the output register and drops imem_req. FETCH_ALIGN_CHECK_EN traps misaligned redirects.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       jump,
    input  logic [31:0]                jump_addr,
    input  logic                       branch_taken,
    input  logic [31:0]                branch_addr,
    input  logic                       stall,
    input  logic                       halt,
    fetch_controller_if.master         imem,
    output logic                       if_valid,
    output logic [31:0]                if_pc,
    output logic [31:0]                if_instr,
    output logic                       halted,
    output logic                       fetch_fault
);

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {FETCH, WAIT_DROP, HALTED, FAULT} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] pend_pc, pend_nx;
    logic        vld_nx;
    logic [31:0] ipc_nx, ins_nx;
    logic        give, redir;
    logic [31:0] tgt, drop_tgt;

    assign give  = if_valid && stall;
    assign redir = jump || branch_taken;

    always_comb begin
        tgt = jump ? jump_addr : branch_addr;
        if (!ALIGN_CHECK)
            tgt[1:0] = 2'b00;
    end

    // In WAIT_DROP a same-cycle redirect supersedes the saved target.
    assign drop_tgt = redir ? tgt : pend_pc;

    assign imem.imem_req  = !rst && (((state == FETCH) && !give && !halt) || (state == WAIT_DROP));
    assign imem.imem_addr = pc;
    assign halted         = (state == HALTED);
    assign fetch_fault    = ALIGN_CHECK && (state == FAULT);

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        pend_nx  = pend_pc;
        vld_nx   = if_valid;
        ipc_nx   = if_pc;
        ins_nx   = if_instr;
        case (state)
            FETCH: begin
                if (redir) begin
                    vld_nx = 1'b0;
                    if (imem.imem_req && !imem.imem_ready) begin
                        pend_nx  = tgt;
                        state_nx = WAIT_DROP;
                    end else if (ALIGN_CHECK && tgt[1:0] != 2'b00) begin
                        state_nx = FAULT;
                    end else begin
                        pc_nx = tgt;
                    end
                end else if (imem.imem_req && imem.imem_ready) begin
                    vld_nx = 1'b1;
                    ipc_nx = pc;
                    ins_nx = imem.imem_rdata;
                    pc_nx  = pc + 32'd4;
                end else if (!stall) begin
                    vld_nx = 1'b0;
                end
                if (halt && state_nx == FETCH)
                    state_nx = HALTED;
            end
            WAIT_DROP: begin
                if (redir)
                    pend_nx = tgt;
                if (redir || !stall)
                    vld_nx = 1'b0;
                if (imem.imem_ready) begin
                    if (ALIGN_CHECK && drop_tgt[1:0] != 2'b00) begin
                        state_nx = FAULT;
                    end else begin
                        pc_nx    = drop_tgt;
                        state_nx = FETCH;
                    end
                end
            end
            HALTED: begin
                if (redir) begin
                    vld_nx = 1'b0;
                    if (ALIGN_CHECK && tgt[1:0] != 2'b00)
                        state_nx = FAULT;
                    else
                        pc_nx = tgt;
                end else if (!stall) begin
                    vld_nx = 1'b0;
                end
                if (!halt && state_nx == HALTED)
                    state_nx = FETCH;
            end
            default: vld_nx = 1'b0;
        endcase
        if (state_nx == FAULT)
            vld_nx = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            pend_pc  <= RESET_PC;
            if_valid <= 1'b0;
            if_pc    <= 32'h0;
            if_instr <= 32'h0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            pend_pc  <= pend_nx;
            if_valid <= vld_nx;
            if_pc    <= ipc_nx;
            if_instr <= ins_nx;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed test-plan scenarios then random traffic vs a behavioural model.
module tb_fetch_controller;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump = 1'b0, branch_taken = 1'b0, stall = 1'b0, halt = 1'b0;
    logic [31:0] jump_addr = 32'h0, branch_addr = 32'h0;
    logic        if_valid, halted, fetch_fault;
    logic [31:0] if_pc, if_instr;

    fetch_controller_if bus ();

    fetch_controller dut (
        .clk(clk), .rst(rst), .jump(jump), .jump_addr(jump_addr),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .stall(stall), .halt(halt), .imem(bus),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .halted(halted), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: where the PC is, whether the current memory response is to be thrown
    // away, whether fetching is parked or dead, and what decode is currently holding.
    logic [31:0] m_pc, m_pend, m_ipc, m_ins;
    bit          m_discard, m_parked, m_dead, m_full;

    task automatic model_reset();
        m_pc = 32'h0; m_pend = 32'h0; m_ipc = 32'h0; m_ins = 32'h0;
        m_discard = 0; m_parked = 0; m_dead = 0; m_full = 0;
    endtask

    function automatic bit bad_addr(input logic [31:0] a);
        return CHK_EN && (a[1:0] != 2'b00);
    endfunction

    task automatic cyc(input bit j, input logic [31:0] ja, input bit b, input logic [31:0] ba,
                       input bit s, input bit h, input bit r);
        bit          req, redir, hold;
        logic [31:0] t, dest;
        @(negedge clk);
        jump = j; jump_addr = ja; branch_taken = b; branch_addr = ba;
        stall = s; halt = h; bus.imem_ready = r;
        bus.imem_rdata = bus.imem_addr ^ KEY;
        #1;
        hold  = m_full && s;
        req   = !m_dead && !m_parked && (m_discard || (!hold && !h));
        redir = j || b;
        t     = j ? ja : ba;
        if (!CHK_EN) t[1:0] = 2'b00;

        check_val("imem_req", bus.imem_req, req);
        check_val("imem_addr", bus.imem_addr, m_pc);
        check_val("if_valid", if_valid, m_full);
        if (m_full) begin
            check_val("if_pc", if_pc, m_ipc);
            check_val("if_instr", if_instr, m_ins);
        end
        check_val("halted", halted, m_parked && !m_dead);
        check_val("fetch_fault", fetch_fault, m_dead);

        if (m_dead) begin
            m_full = 0;
        end else if (m_discard) begin
            if (redir) m_pend = t;
            if (redir || !s) m_full = 0;
            if (r) begin
                m_discard = 0;
                if (bad_addr(m_pend)) m_dead = 1; else m_pc = m_pend;
            end
        end else if (m_parked) begin
            if (redir) begin
                m_full = 0;
                if (bad_addr(t)) m_dead = 1; else m_pc = t;
            end else if (!s) m_full = 0;
            if (!h) m_parked = 0;
        end else begin
            if (redir) begin
                m_full = 0;
                if (req && !r) begin m_discard = 1; m_pend = t; end
                else if (bad_addr(t)) m_dead = 1;
                else m_pc = t;
            end else if (req && r) begin
                m_full = 1; m_ipc = m_pc; m_ins = m_pc ^ KEY; m_pc = m_pc + 32'd4;
            end else if (!s) m_full = 0;
            if (h && !m_dead && !m_discard) m_parked = 1;
        end
        if (m_dead) m_full = 0;
        dest = m_pc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        jump = 0; branch_taken = 0; stall = 0; halt = 0; bus.imem_ready = 1'b0;
        #1;
        check_val("rst_req", bus.imem_req, 1'b0);
        check_val("rst_valid", if_valid, 1'b0);
        check_val("rst_instr", if_instr, 32'h0);
        check_val("rst_pc", if_pc, 32'h0);
        check_val("rst_addr", bus.imem_addr, 32'h0);
        check_val("rst_halted", halted, 1'b0);
        check_val("rst_fault", fetch_fault, 1'b0);
        @(negedge clk);
        check_val("rst_req_hold", bus.imem_req, 1'b0);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [31:0] raddr();
        logic [31:0] a;
        a = $urandom & 32'h0000_03FC;
        if ($urandom_range(0, 31) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        model_reset();
        rst = 1'b1;
        #12 rst = 1'b0;

        // Reset arriving while a fetch waits on memory.
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 1);
        check_val("post_rst_first_addr_is_0", m_ipc, 32'h0);

        // Zero-wait stream.
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0, 1);

        // Two wait states per fetch, then a 3-cycle stall.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0, 0, 1);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1);

        // Jump beats branch.
        cyc(1, 32'h100, 1, 32'h200, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check_val("prio_target", m_ipc, 32'h100);
        cyc(0, 0, 0, 0, 0, 0, 1);

        // Squash: branch to 0x40 while fetch at 0x10 waits.
        cyc(1, 32'h10, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 32'h40, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check_val("squash_next", m_ipc, 32'h40);
        cyc(0, 0, 0, 0, 0, 0, 1);

        // Halt for 4 cycles then resume.
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1);

        // PC wrap.
        cyc(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1);
        check_val("wrap", m_pc, 32'h8);

        // Misaligned jump: fault or masked target depending on build.
        cyc(1, 32'h102, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1);
        do_reset();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if (n % 300 == 299) do_reset();
            cyc($urandom_range(0, 15) == 0, raddr(), $urandom_range(0, 11) == 0, raddr(),
                $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
